// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, opcode classifiers.
// Optional feature macro: ALU_SIGNED_MD_EN (signed multiply/divide opcodes).
package alu_seq_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_SMUL = 5'b00100;
    localparam logic [4:0] OP_SDIV = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b01100;
    localparam logic [4:0] OP_SHL  = 5'b01101;
    localparam logic [4:0] OP_SHR  = 5'b01110;
    localparam logic [4:0] OP_SRA  = 5'b01111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Opcodes that run through the multi-cycle multiply/divide core
    function automatic logic is_iterative(input logic [4:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_MUL, OP_DIV: r = 1'b1;
`ifdef ALU_SIGNED_MD_EN
            OP_SMUL, OP_SDIV: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Divide-type opcodes (the core runs its restoring-divide step for these)
    function automatic logic is_div(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_SDIV);
    endfunction

    // Signed multiply/divide opcodes
    function automatic logic is_signed(input logic [4:0] op);
        return (op == OP_SMUL) || (op == OP_SDIV);
    endfunction

endpackage

// File: rtl/alu_seq_md_core.sv
// Iterative multiply/divide datapath: one shift-add (or Booth) step or one
// restoring-divide step per cycle, WIDTH steps after load.
// Optional feature macro: ALU_SIGNED_MD_EN (Booth multiply, signed divide sign-fix).
module alu_seq_md_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // acc_r is one bit wider than WIDTH to hold the adder carry / divide sign
    logic [WIDTH:0]     acc_r;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   m_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               div_r;
`ifdef ALU_SIGNED_MD_EN
    logic               sgn_r;
    logic               qm1_r;
    logic               neg_q_r;
    logic               neg_r_r;
`endif

    logic [WIDTH:0]     m_ext_s;
    logic [WIDTH:0]     t_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;
    logic               add_s;
    logic               sub_s;
    logic               fill_s;

    // Next partial product / partial remainder for the current step
    always_comb begin
`ifdef ALU_SIGNED_MD_EN
        m_ext_s = {sgn_r & m_r[WIDTH-1], m_r};
        if (sgn_r) begin
            add_s = ~q_r[0] & qm1_r;
            sub_s = q_r[0] & ~qm1_r;
        end else begin
            add_s = q_r[0];
            sub_s = 1'b0;
        end
`else
        m_ext_s = {1'b0, m_r};
        add_s   = q_r[0];
        sub_s   = 1'b0;
`endif
        if (add_s) begin
            t_s = acc_r + m_ext_s;
        end else if (sub_s) begin
            t_s = acc_r - m_ext_s;
        end else begin
            t_s = acc_r;
        end
`ifdef ALU_SIGNED_MD_EN
        fill_s = sgn_r & t_s[WIDTH];
`else
        fill_s = 1'b0;
`endif
        shifted_s = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, m_r};
    end

    // Datapath registers: load operands, then iterate until the counter empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= '0;
            q_r     <= '0;
            m_r     <= '0;
            cnt_r   <= '0;
            div_r   <= 1'b0;
`ifdef ALU_SIGNED_MD_EN
            sgn_r   <= 1'b0;
            qm1_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
`endif
        end else if (load) begin
            acc_r <= '0;
            cnt_r <= CNT_W'(WIDTH);
            div_r <= is_div(op);
`ifdef ALU_SIGNED_MD_EN
            sgn_r <= is_signed(op) && !is_div(op);
            qm1_r <= 1'b0;
            if (is_div(op) && is_signed(op)) begin
                // Divide magnitudes; signs are restored on the way out
                q_r     <= a[WIDTH-1] ? -a : a;
                m_r     <= b[WIDTH-1] ? -b : b;
                neg_q_r <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_r_r <= a[WIDTH-1];
            end else begin
                q_r     <= a;
                m_r     <= b;
                neg_q_r <= 1'b0;
                neg_r_r <= 1'b0;
            end
`else
            q_r   <= a;
            m_r   <= b;
`endif
        end else if (step && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (div_r) begin
                if (!diff_s[WIDTH]) begin
                    acc_r <= diff_s;
                    q_r   <= {q_r[WIDTH-2:0], 1'b1};
                end else begin
                    acc_r <= shifted_s;
                    q_r   <= {q_r[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_r <= {fill_s, t_s[WIDTH:1]};
                q_r   <= {t_s[0], q_r[WIDTH-1:1]};
`ifdef ALU_SIGNED_MD_EN
                qm1_r <= q_r[0];
`endif
            end
        end
    end

    // Present product halves or quotient/remainder (sign-corrected when signed)
    always_comb begin
        lo = q_r;
        hi = acc_r[WIDTH-1:0];
`ifdef ALU_SIGNED_MD_EN
        if (div_r && neg_q_r) begin
            lo = -q_r;
        end else begin
            lo = q_r;
        end
        if (div_r && neg_r_r) begin
            hi = -acc_r[WIDTH-1:0];
        end else begin
            hi = acc_r[WIDTH-1:0];
        end
`endif
        done = (cnt_r == '0);
    end

endmodule

// File: rtl/alu_seq_param.sv
// Parametrised multi-cycle ALU top: accept handshake, FSM, single-cycle ops,
// registered results. MUL/DIV run in alu_seq_md_core.
// Optional feature macro: ALU_SIGNED_MD_EN (SMUL/SDIV opcodes).
module alu_seq_param
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bgn,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             stop,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             err
);

    localparam int SH_W = $clog2(WIDTH);
`ifdef ALU_SIGNED_MD_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_t             state_r;
    state_t             state_nx_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [SEL_W-1:0]   sel_r;
    logic [WIDTH-1:0]   out_r;
    logic [WIDTH-1:0]   out_hi_r;
    logic               err_r;
    logic               stop_r;

    logic               accept_s;
    logic [4:0]         op_s;
    logic               op_ext_s;
    logic               iter_s;
    logic [WIDTH-1:0]   md_lo_s;
    logic [WIDTH-1:0]   md_hi_s;
    logic               md_done_s;
    logic [WIDTH-1:0]   res_lo_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic               res_err_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     dif_s;
    logic [SH_W-1:0]    sh_s;

    assign accept_s = (state_r == S_IDLE) && bgn;
    assign op_s     = 5'(sel_r);
    // Opcode bits above the 5-bit opcode space make the opcode illegal
    assign op_ext_s = |(sel_r >> 5);
    assign iter_s   = is_iterative(op_s) && !op_ext_s;

    alu_seq_md_core #(.WIDTH(WIDTH)) u_md (
        .clk  (clk),
        .rst  (rst),
        .load (accept_s),
        .step (state_r == S_EXEC),
        .op   (5'(sel)),
        .a    (in_0),
        .b    (in_1),
        .lo   (md_lo_s),
        .hi   (md_hi_s),
        .done (md_done_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state: iterative ops leave EXEC when the core counter empties
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bgn) begin
                    state_nx_s = S_EXEC;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_EXEC: begin
                if (!iter_s || md_done_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_EXEC;
                end
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Operand capture on accept; later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            sel_r <= '0;
        end else if (accept_s) begin
            a_r   <= in_0;
            b_r   <= in_1;
            sel_r <= sel;
        end
    end

    // Result selection for the latched opcode
    always_comb begin
        res_lo_s  = '0;
        res_hi_s  = '0;
        res_err_s = 1'b0;
        sum_s     = {1'b0, a_r} + {1'b0, b_r};
        dif_s     = {1'b0, a_r} - {1'b0, b_r};
        sh_s      = b_r[SH_W-1:0];
        if (op_ext_s) begin
            res_err_s = 1'b1;
        end else begin
            case (op_s)
                OP_ADD: begin
                    res_lo_s = sum_s[WIDTH-1:0];
                    res_hi_s = WIDTH'(sum_s[WIDTH]);
                end
                OP_SUB: begin
                    res_lo_s = dif_s[WIDTH-1:0];
                    res_hi_s = WIDTH'(dif_s[WIDTH]);
                end
                OP_MUL: begin
                    res_lo_s = md_lo_s;
                    res_hi_s = md_hi_s;
                end
                OP_DIV: begin
                    if (b_r == '0) begin
                        res_lo_s  = '1;
                        res_hi_s  = a_r;
                        res_err_s = 1'b1;
                    end else begin
                        res_lo_s  = md_lo_s;
                        res_hi_s  = md_hi_s;
                    end
                end
`ifdef ALU_SIGNED_MD_EN
                OP_SMUL: begin
                    res_lo_s = md_lo_s;
                    res_hi_s = md_hi_s;
                end
                OP_SDIV: begin
                    if (b_r == '0) begin
                        res_lo_s  = '1;
                        res_hi_s  = a_r;
                        res_err_s = 1'b1;
                    end else begin
                        res_lo_s  = md_lo_s;
                        res_hi_s  = md_hi_s;
                        res_err_s = (a_r == MOST_NEG) && (b_r == '1);
                    end
                end
`endif
                OP_AND:  res_lo_s = a_r & b_r;
                OP_OR:   res_lo_s = a_r | b_r;
                OP_XOR:  res_lo_s = a_r ^ b_r;
                OP_NOT:  res_lo_s = ~a_r;
                OP_SHL:  res_lo_s = a_r << sh_s;
                OP_SHR:  res_lo_s = a_r >> sh_s;
                OP_SRA:  res_lo_s = WIDTH'($signed(a_r) >>> sh_s);
                default: res_err_s = 1'b1;
            endcase
        end
    end

    // Output registers: load on EXEC->DONE, hold until the next completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r    <= '0;
            out_hi_r <= '0;
            err_r    <= 1'b0;
            stop_r   <= 1'b0;
        end else if ((state_r == S_EXEC) && (state_nx_s == S_DONE)) begin
            out_r    <= res_lo_s;
            out_hi_r <= res_hi_s;
            err_r    <= res_err_s;
            stop_r   <= 1'b1;
        end else begin
            stop_r   <= 1'b0;
        end
    end

    assign stop   = stop_r;
    assign out    = out_r;
    assign out_hi = out_hi_r;
    assign err    = err_r;
    // Busy covers the accept cycle itself, hence the bgn term while IDLE
    assign busy   = ~rst & ((state_r != S_IDLE) | bgn);

endmodule
